// File: rtl/processor_sharing_result_return_if.sv
// Result-return bus: two processor result ports, four stream sinks, fill levels and drop counter.
// The slave modport is the return-path block; the master modport is the processors plus consumers.
interface processor_sharing_result_return_if #(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned DROP_W = 8
);
    logic [15:0]            proc0_data;
    logic                   proc0_ready;
    logic [15:0]            proc1_data;
    logic                   proc1_ready;
    logic [3:0][15:0]       sink_data;
    logic [3:0]             sink_valid;
    logic [3:0]             sink_ready;
    logic [3:0][CNT_W-1:0]  fill;
    logic [DROP_W-1:0]      drop_count;

    modport master (
        output proc0_data, proc1_data, sink_ready,
        input  proc0_ready, proc1_ready, sink_data, sink_valid, fill, drop_count
    );

    modport slave (
        input  proc0_data, proc1_data, sink_ready,
        output proc0_ready, proc1_ready, sink_data, sink_valid, fill, drop_count
    );
endinterface

// File: rtl/processor_sharing_result_return.sv
// Return path of the 4x2 processor-sharing model: routes PROC0/PROC1 results by tag into
// one FIFO per stream (A..D), drained by valid/ready sinks; illegal tags are counted and dropped.
module processor_sharing_result_return #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned DROP_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    processor_sharing_result_return_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NS    = 4;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic             legal0, legal1;
    logic             ill0, ill1;
    logic             acc0, acc1;
    logic [1:0]       t0, t1;
    logic [CNT_W:0]   occ0, occ1;
    logic [CNT_W-1:0] fill_q [NS];

    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;

    // Returns {legal, stream index}; zero and unknown tags come back as not legal.
    function automatic logic [2:0] decode_tag(input logic [3:0] tag);
        case (tag)
            4'hA:    return 3'b100;
            4'hB:    return 3'b101;
            4'hC:    return 3'b110;
            4'hD:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Room is judged on registered fill only, so no sink_ready term reaches proc ready.
    always_comb begin
        {legal0, t0} = decode_tag(bus.proc0_data[15:12]);
        {legal1, t1} = decode_tag(bus.proc1_data[15:12]);
        ill0 = (bus.proc0_data != '0) && !legal0;
        ill1 = (bus.proc1_data != '0) && !legal1;

        occ0 = {1'b0, fill_q[t0]};
        acc0 = legal0 && (occ0 < DEPTH_C);
        occ1 = {1'b0, fill_q[t1]} + {{CNT_W{1'b0}}, (acc0 && (t0 == t1))};
        acc1 = legal1 && (occ1 < DEPTH_C);

        bus.proc0_ready = !legal0 || (occ0 < DEPTH_C);
        bus.proc1_ready = !legal1 || (occ1 < DEPTH_C);
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(ill0) + (DROP_W+1)'(ill1);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign bus.drop_count = drop_q;

    for (genvar s = 0; s < NS; s++) begin : g_stream
        logic             push0, push1, pop;
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [15:0]      mem_q [DEPTH];

        always_comb begin
            push0    = acc0 && (t0 == 2'(s));
            push1    = acc1 && (t1 == 2'(s));
            pop      = (cnt_q != '0) && bus.sink_ready[s];
            wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            cnt_d    = cnt_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Same-tag double accept: PROC0 lands first, PROC1 in the following slot.
        always_ff @(posedge clk) begin
            if (push0) mem_q[wr_ptr_q] <= bus.proc0_data;
            if (push1) mem_q[wr_ptr_q + PTR_W'(push0)] <= bus.proc1_data;
        end

        assign fill_q[s]         = cnt_q;
        assign bus.fill[s]       = cnt_q;
        assign bus.sink_valid[s] = (cnt_q != '0);
        assign bus.sink_data[s]  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_processor_sharing_result_return.sv
// Directed bench for the result-return path: routing, ordering, backpressure, drops, reset.
module tb_processor_sharing_result_return;
    logic clk = 1'b0;
    logic rst_n;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] q[$];
    logic [15:0] exp_c [4] = '{16'hC002, 16'hC003, 16'hC004, 16'hC010};
    logic [15:0] exp_d [4] = '{16'hD002, 16'hD003, 16'hD020, 16'hD021};
    logic [15:0] word;
    logic        exp_acc, exp_pop;
    int unsigned sent, cyc;

    processor_sharing_result_return_if #(.CNT_W(3), .DROP_W(8)) bus ();

    processor_sharing_result_return #(.DEPTH(4), .CNT_W(3), .DROP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.proc0_data = '0;
        bus.proc1_data = '0;
        bus.sink_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.sink_valid), 64'd0);
        chk("rst_fill",  64'(bus.fill), 64'd0);
        chk("rst_data",  64'(bus.sink_data), 64'd0);
        chk("rst_drop",  64'(bus.drop_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single word on stream A, one-cycle latency
        bus.proc0_data = 16'hA001;
        #1 chk("t1_ready0", 64'(bus.proc0_ready), 64'd1);
        chk("t1_valid_pre", 64'(bus.sink_valid[0]), 64'd0);
        tick();
        bus.proc0_data = '0;
        chk("t1_valid0", 64'(bus.sink_valid[0]), 64'd1);
        chk("t1_data0",  64'(bus.sink_data[0]), 64'hA001);
        chk("t1_fill0",  64'(bus.fill[0]), 64'd1);
        bus.sink_ready[0] = 1'b1;
        tick();
        bus.sink_ready[0] = 1'b0;
        chk("t1_fill0_pop", 64'(bus.fill[0]), 64'd0);
        chk("t1_data0_pop", 64'(bus.sink_data[0]), 64'd0);

        // 2: same-tag double accept, PROC0 first
        bus.proc0_data = 16'hB002;
        bus.proc1_data = 16'hB003;
        #1 chk("t2_ready0", 64'(bus.proc0_ready), 64'd1);
        chk("t2_ready1", 64'(bus.proc1_ready), 64'd1);
        tick();
        bus.proc0_data = '0;
        bus.proc1_data = '0;
        chk("t2_fill1", 64'(bus.fill[1]), 64'd2);
        chk("t2_head0", 64'(bus.sink_data[1]), 64'hB002);
        bus.sink_ready[1] = 1'b1;
        tick();
        chk("t2_head1", 64'(bus.sink_data[1]), 64'hB003);
        chk("t2_fill1b", 64'(bus.fill[1]), 64'd1);
        tick();
        bus.sink_ready[1] = 1'b0;
        chk("t2_empty", 64'(bus.sink_valid[1]), 64'd0);

        // 3: full stream C, same-cycle pop does not free space
        bus.proc0_data = 16'hC001;
        bus.proc1_data = 16'hC002;
        tick();
        bus.proc0_data = 16'hC003;
        bus.proc1_data = 16'hC004;
        tick();
        bus.proc0_data = 16'hC010;
        bus.proc1_data = '0;
        #1 chk("t3_fill2_full", 64'(bus.fill[2]), 64'd4);
        chk("t3_ready0_full", 64'(bus.proc0_ready), 64'd0);
        tick();
        chk("t3_fill2_hold", 64'(bus.fill[2]), 64'd4);
        chk("t3_head", 64'(bus.sink_data[2]), 64'hC001);
        bus.sink_ready[2] = 1'b1;
        #1 chk("t3_ready0_popcyc", 64'(bus.proc0_ready), 64'd0);
        tick();
        bus.sink_ready[2] = 1'b0;
        chk("t3_fill2_after_pop", 64'(bus.fill[2]), 64'd3);
        #1 chk("t3_ready0_room", 64'(bus.proc0_ready), 64'd1);
        tick();
        bus.proc0_data = '0;
        chk("t3_fill2_refull", 64'(bus.fill[2]), 64'd4);
        bus.sink_ready[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3_drain", 64'(bus.sink_data[2]), 64'(exp_c[i]));
            tick();
        end
        bus.sink_ready[2] = 1'b0;
        chk("t3_fill2_empty", 64'(bus.fill[2]), 64'd0);

        // 4: fill3=3, PROC0 takes the last slot, PROC1 retries
        bus.proc0_data = 16'hD001;
        bus.proc1_data = 16'hD002;
        tick();
        bus.proc0_data = 16'hD003;
        bus.proc1_data = '0;
        tick();
        chk("t4_fill3", 64'(bus.fill[3]), 64'd3);
        bus.proc0_data = 16'hD020;
        bus.proc1_data = 16'hD021;
        #1 chk("t4_ready0", 64'(bus.proc0_ready), 64'd1);
        chk("t4_ready1", 64'(bus.proc1_ready), 64'd0);
        tick();
        bus.proc0_data = '0;
        chk("t4_fill3_full", 64'(bus.fill[3]), 64'd4);
        bus.sink_ready[3] = 1'b1;
        #1 chk("t4_ready1_popcyc", 64'(bus.proc1_ready), 64'd0);
        tick();
        bus.sink_ready[3] = 1'b0;
        chk("t4_fill3_pop", 64'(bus.fill[3]), 64'd3);
        #1 chk("t4_ready1_retry", 64'(bus.proc1_ready), 64'd1);
        tick();
        bus.proc1_data = '0;
        chk("t4_fill3_refull", 64'(bus.fill[3]), 64'd4);
        bus.sink_ready[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t4_drain", 64'(bus.sink_data[3]), 64'(exp_d[i]));
            tick();
        end
        bus.sink_ready[3] = 1'b0;
        chk("t4_fill3_empty", 64'(bus.fill[3]), 64'd0);

        // 5: illegal tags on both processors, then saturation
        bus.proc0_data = 16'hE123;
        bus.proc1_data = 16'h7FFF;
        #1 chk("t5_ready0", 64'(bus.proc0_ready), 64'd1);
        chk("t5_ready1", 64'(bus.proc1_ready), 64'd1);
        tick();
        chk("t5_drop2", 64'(bus.drop_count), 64'd2);
        chk("t5_fills", 64'(bus.fill), 64'd0);
        bus.proc0_data = 16'h1234;
        bus.proc1_data = 16'h9FFF;
        repeat (126) tick();
        chk("t5_drop254", 64'(bus.drop_count), 64'd254);
        tick();
        chk("t5_drop_sat", 64'(bus.drop_count), 64'd255);
        tick();
        chk("t5_drop_hold", 64'(bus.drop_count), 64'd255);
        bus.proc0_data = '0;
        bus.proc1_data = '0;
        chk("t5_fills_end", 64'(bus.fill), 64'd0);

        // 6: stream A wrap with toggling sink ready, order against a queue
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 40) begin
            word              = 16'hA100 + 16'(sent);
            bus.proc0_data    = word;
            bus.sink_ready[0] = cyc[0];
            #1;
            exp_acc = (q.size() < 4);
            exp_pop = (q.size() != 0) && cyc[0];
            chk("t6_ready0", 64'(bus.proc0_ready), 64'(exp_acc));
            tick();
            if (exp_pop) void'(q.pop_front());
            if (exp_acc) begin
                q.push_back(word);
                sent++;
            end
            chk("t6_fill0", 64'(bus.fill[0]), 64'(q.size()));
            chk("t6_data0", 64'(bus.sink_data[0]), (q.size() != 0) ? 64'(q[0]) : 64'd0);
            cyc++;
        end
        chk("t6_all_sent", 64'(sent), 64'd10);

        // Reset mid-stream clears everything asynchronously
        bus.proc0_data    = 16'hA1FF;
        bus.sink_ready[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_valid", 64'(bus.sink_valid), 64'd0);
        chk("t6_rst_fill", 64'(bus.fill), 64'd0);
        chk("t6_rst_data", 64'(bus.sink_data), 64'd0);
        chk("t6_rst_drop", 64'(bus.drop_count), 64'd0);
        bus.proc0_data = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_post_valid", 64'(bus.sink_valid), 64'd0);
        chk("t6_post_fill", 64'(bus.fill), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
